// File: rtl/hpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hpu_pkg                                                |
// | Description : Shared sizing constants and types for the rename       |
// |               free list: physical index, checkpoint index and the    |
// |               wrap-bit free-list pointer.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package hpu_pkg;

   localparam int DEC_PARAL    = 2;
   localparam int COMMIT_PARAL = 2;
   localparam int PHY_SR_LEN   = 64;
   localparam int CKPT_LEN     = 4;

   localparam int PHY_IDX_W  = $clog2(PHY_SR_LEN);
   localparam int CKPT_IDX_W = $clog2(CKPT_LEN);
   localparam int FL_DEPTH   = PHY_SR_LEN;
   // One extra bit so that full and empty are distinguishable.
   localparam int FL_PTR_W   = $clog2(FL_DEPTH) + 1;

   typedef logic [PHY_IDX_W-1:0]  phy_sr_index_t;
   typedef logic [CKPT_IDX_W-1:0] ckpt_index_t;
   typedef logic [FL_PTR_W-1:0]   fl_ptr_t;

   // Storage slot addressed by a wrap-bit pointer.
   function automatic phy_sr_index_t fl_slot(input fl_ptr_t p);
      return p[PHY_IDX_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/hpu_ren_fl_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hpu_ren_fl_ckpt                                        |
// | Description : CKPT_LEN x fl_ptr_t register file holding speculative  |
// |               free-list heads saved at branch rename.                |
// |   clk, rst   : clock, synchronous active-high reset                  |
// |   i_wr_*     : save port (index, head value)                         |
// |   i_rd_index : recover port index; o_rd_head is the stored head      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hpu_ren_fl_ckpt
   import hpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [CKPT_IDX_W-1:0] i_wr_index,
   input  logic [FL_PTR_W-1:0]   i_wr_head,
   input  logic [CKPT_IDX_W-1:0] i_rd_index,
   output logic [FL_PTR_W-1:0]   o_rd_head
);

   fl_ptr_t r_head [CKPT_LEN];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < CKPT_LEN; k++) r_head[k] <= '0;
      end else if (i_wr_en) begin
         r_head[i_wr_index] <= i_wr_head;
      end
   end

   // Read the registered array directly: a same-cycle save to the same
   // slot is not visible to the recovery.
   assign o_rd_head = r_head[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/hpu_ren_freelist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hpu_ren_freelist                                       |
// | Description : Physical-register free list feeding the rename RAT.    |
// |               Circular buffer of physical indices with speculative   |
// |               head, committed head (rhead) and tail pointers.        |
// |   alloc_*    : id0 allocation (zero-latency read, head advance)      |
// |   release_*  : commit returns old destinations at the tail           |
// |   retire_*   : advances the committed head                           |
// |   ckpt_*     : branch checkpoint save (id1) / recovery               |
// |   arat_*     : full flush back to the committed head                 |
// | Optional    : HPU_FREELIST_CHK_EN adds simulation assertions and a   |
// |               shadow occupancy bitmap for duplicate-release checks.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hpu_ren_freelist
   import hpu_pkg::*;
(
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [DEC_PARAL-1:0]              alloc_req_id0_i,
   input  logic                              alloc_fire_id0_i,
   output logic                              alloc_rdy_id0_o,
   output logic [DEC_PARAL*PHY_IDX_W-1:0]    phy_rdst_index_id0_o,
   input  logic [COMMIT_PARAL-1:0]           release_en_i,
   input  logic [COMMIT_PARAL*PHY_IDX_W-1:0] release_index_i,
   input  logic [COMMIT_PARAL-1:0]           retire_alloc_en_i,
   input  logic                              ckpt_save_en_id1_i,
   input  logic [CKPT_IDX_W-1:0]             ckpt_save_index_id1_i,
   input  logic                              ckpt_rcov_en_i,
   input  logic [CKPT_IDX_W-1:0]             ckpt_rcov_index_i,
   input  logic                              arat_rcov_en_i
);

   phy_sr_index_t r_entry [FL_DEPTH];
   fl_ptr_t       r_head;
   fl_ptr_t       r_rhead;
   fl_ptr_t       r_tail;

   fl_ptr_t       w_count;
   fl_ptr_t       w_alloc_cnt;
   fl_ptr_t       w_rel_cnt;
   fl_ptr_t       w_ret_cnt;
   fl_ptr_t       w_head_nxt;
   fl_ptr_t       w_ckpt_head;
   logic          w_alloc_ok;
   logic [COMMIT_PARAL-1:0] w_rel_vld;
   phy_sr_index_t w_rel_idx  [COMMIT_PARAL];
   phy_sr_index_t w_rel_addr [COMMIT_PARAL];

   // Ready looks only at registered pointers, never at the request inputs.
   assign w_count         = r_tail - r_head;
   assign alloc_rdy_id0_o = (w_count >= fl_ptr_t'(DEC_PARAL));
   assign w_alloc_ok      = alloc_fire_id0_i && alloc_rdy_id0_o;

   // Slot i reads the entry after all earlier requesting slots; a
   // non-requesting slot shows the candidate of the next requester.
   always_comb begin
      w_alloc_cnt          = '0;
      phy_rdst_index_id0_o = '0;
      for (int i = 0; i < DEC_PARAL; i++) begin
         phy_rdst_index_id0_o[i*PHY_IDX_W +: PHY_IDX_W] = r_entry[fl_slot(r_head + w_alloc_cnt)];
         w_alloc_cnt = w_alloc_cnt + fl_ptr_t'(alloc_req_id0_i[i]);
      end
   end

   // Released index 0 (x0) is never put back; valid releases pack densely.
   always_comb begin
      w_rel_cnt = '0;
      w_rel_vld = '0;
      for (int j = 0; j < COMMIT_PARAL; j++) begin
         w_rel_idx[j]  = release_index_i[j*PHY_IDX_W +: PHY_IDX_W];
         w_rel_vld[j]  = release_en_i[j] && (w_rel_idx[j] != '0);
         w_rel_addr[j] = fl_slot(r_tail + w_rel_cnt);
         w_rel_cnt     = w_rel_cnt + fl_ptr_t'(w_rel_vld[j]);
      end
   end

   always_comb begin
      w_ret_cnt = '0;
      for (int j = 0; j < COMMIT_PARAL; j++) begin
         w_ret_cnt = w_ret_cnt + fl_ptr_t'(retire_alloc_en_i[j]);
      end
   end

   // Recovery overrides allocation; the flush includes this cycle's retires.
   always_comb begin
      if (arat_rcov_en_i) begin
         w_head_nxt = r_rhead + w_ret_cnt;
      end else if (ckpt_rcov_en_i) begin
         w_head_nxt = w_ckpt_head;
      end else if (w_alloc_ok) begin
         w_head_nxt = r_head + w_alloc_cnt;
      end else begin
         w_head_nxt = r_head;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < FL_DEPTH; k++) begin
            r_entry[k] <= (k < FL_DEPTH-1) ? phy_sr_index_t'(k+1) : '0;
         end
         r_head  <= '0;
         r_rhead <= '0;
         r_tail  <= fl_ptr_t'(PHY_SR_LEN-1);
      end else begin
         for (int j = 0; j < COMMIT_PARAL; j++) begin
            if (w_rel_vld[j]) r_entry[w_rel_addr[j]] <= w_rel_idx[j];
         end
         r_tail  <= r_tail + w_rel_cnt;
         r_rhead <= r_rhead + w_ret_cnt;
         r_head  <= w_head_nxt;
      end
   end

   // Snapshot is the head before any same-cycle id0 allocation.
   hpu_ren_fl_ckpt u_ckpt (
      .clk        (clk_i),
      .rst        (rst_i),
      .i_wr_en    (ckpt_save_en_id1_i),
      .i_wr_index (ckpt_save_index_id1_i),
      .i_wr_head  (r_head),
      .i_rd_index (ckpt_rcov_index_i),
      .o_rd_head  (w_ckpt_head)
   );

`ifdef HPU_FREELIST_CHK_EN
   // Bit n set means physical index n currently sits between head and tail.
   logic [PHY_SR_LEN-1:0] r_occ;
   logic [PHY_SR_LEN-1:0] w_occ_nxt;
   fl_ptr_t               w_span;

   assign w_span = r_head - w_head_nxt;

   always_comb begin
      phy_sr_index_t ofs;
      ofs       = '0;
      w_occ_nxt = r_occ;
      if (arat_rcov_en_i || ckpt_rcov_en_i) begin
         // Entries between the restored head and the old head return to the free pool.
         for (int k = 0; k < FL_DEPTH; k++) begin
            ofs = phy_sr_index_t'(k) - fl_slot(w_head_nxt);
            if ({1'b0, ofs} < w_span) w_occ_nxt[r_entry[k]] = 1'b1;
         end
      end else if (w_alloc_ok) begin
         for (int i = 0; i < DEC_PARAL; i++) begin
            if (alloc_req_id0_i[i])
               w_occ_nxt[phy_rdst_index_id0_o[i*PHY_IDX_W +: PHY_IDX_W]] = 1'b0;
         end
      end
      for (int j = 0; j < COMMIT_PARAL; j++) begin
         if (w_rel_vld[j]) w_occ_nxt[w_rel_idx[j]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_occ <= {{(PHY_SR_LEN-1){1'b1}}, 1'b0};
      end else begin
         r_occ <= w_occ_nxt;
         assert (!(alloc_fire_id0_i && !alloc_rdy_id0_o))
            else $error("freelist: allocation fired while not ready");
         assert (w_count <= fl_ptr_t'(PHY_SR_LEN-1))
            else $error("freelist: free count above capacity");
         for (int j = 0; j < COMMIT_PARAL; j++) begin
            assert (!(w_rel_vld[j] && r_occ[w_rel_idx[j]]))
               else $error("freelist: duplicate release of index %0d", w_rel_idx[j]);
         end
         assert ((r_tail + w_rel_cnt - w_head_nxt) <= fl_ptr_t'(PHY_SR_LEN-1))
            else $error("freelist: head passed tail");
         assert (arat_rcov_en_i || ((r_head - r_rhead) <= fl_ptr_t'(PHY_SR_LEN-1)))
            else $error("freelist: committed head passed speculative head");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpu_ren_freelist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hpu_ren_freelist                                    |
// | Description : Self-checking bench for hpu_ren_freelist. Directed     |
// |               scenarios with literal expectations, then randomized   |
// |               legal traffic checked against a queue-style model.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hpu_ren_freelist;
   import hpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  alloc_req;
   logic        alloc_fire;
   logic        alloc_rdy;
   logic [11:0] phy_rdst;
   logic [1:0]  rel_en;
   logic [11:0] rel_index;
   logic [1:0]  ret_en;
   logic        save_en;
   logic [1:0]  save_idx;
   logic        rcov_en;
   logic [1:0]  rcov_idx;
   logic        arat_en;

   always #5 clk = ~clk;

   hpu_ren_freelist dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .alloc_req_id0_i       (alloc_req),
      .alloc_fire_id0_i      (alloc_fire),
      .alloc_rdy_id0_o       (alloc_rdy),
      .phy_rdst_index_id0_o  (phy_rdst),
      .release_en_i          (rel_en),
      .release_index_i       (rel_index),
      .retire_alloc_en_i     (ret_en),
      .ckpt_save_en_id1_i    (save_en),
      .ckpt_save_index_id1_i (save_idx),
      .ckpt_rcov_en_i        (rcov_en),
      .ckpt_rcov_index_i     (rcov_idx),
      .arat_rcov_en_i        (arat_en)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: unbounded pointers, storage indexed modulo 64.
   int     m_fl [64];
   longint m_head, m_rhead, m_tail;
   longint m_ckpt [4];
   int     last_s0, last_s1, last_rdy;

   function automatic int slot(input longint p);
      return int'(p % 64);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 64; k++) m_fl[k] = (k < 63) ? k + 1 : 0;
      m_head  = 0;
      m_rhead = 0;
      m_tail  = 63;
      for (int k = 0; k < 4; k++) m_ckpt[k] = 0;
   endtask

   task automatic idle_inputs();
      alloc_req = '0; alloc_fire = 1'b0; rel_en = '0; rel_index = '0;
      ret_en = '0; save_en = 1'b0; save_idx = '0; rcov_en = 1'b0;
      rcov_idx = '0; arat_en = 1'b0;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic step(input logic [1:0] req, input logic fire,
                       input logic [1:0] ren, input int r0, input int r1,
                       input logic [1:0] ret, input logic sv, input int svi,
                       input logic rc, input int rci, input logic ar);
      int     pre;
      int     k;
      longint nh;
      longint rcv;
      logic   exp_rdy;
      alloc_req  = req;
      alloc_fire = fire;
      rel_en     = ren;
      rel_index  = {6'(r1), 6'(r0)};
      ret_en     = ret;
      save_en    = sv;
      save_idx   = 2'(svi);
      rcov_en    = rc;
      rcov_idx   = 2'(rci);
      arat_en    = ar;
      #1;
      last_rdy = int'(alloc_rdy);
      last_s0  = int'(phy_rdst[5:0]);
      last_s1  = int'(phy_rdst[11:6]);
      exp_rdy  = (m_tail - m_head) >= 2;
      chk("rdy", int'(alloc_rdy), int'(exp_rdy));
      if (exp_rdy) begin
         pre = 0;
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("slot%0d", i), int'(phy_rdst[i*6 +: 6]), m_fl[slot(m_head + pre)]);
            pre += int'(req[i]);
         end
      end
      rcv = m_ckpt[rci];
      if (ar)                    nh = m_rhead + ret[0] + ret[1];
      else if (rc)               nh = rcv;
      else if (fire && exp_rdy)  nh = m_head + req[0] + req[1];
      else                       nh = m_head;
      if (sv) m_ckpt[svi] = m_head;
      k = 0;
      if (ren[0] && r0 != 0) begin m_fl[slot(m_tail + k)] = r0; k++; end
      if (ren[1] && r1 != 0) begin m_fl[slot(m_tail + k)] = r1; k++; end
      m_tail  += k;
      m_rhead += ret[0] + ret[1];
      m_head   = nh;
      @(negedge clk);
   endtask

   task automatic fire2();
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      logic [1:0] req, ren, ret;
      logic       fire, sv, rc, ar;
      int         r0, r1, svi, rci, nrel, nret;

      rst = 1'b1;
      idle_inputs();
      @(negedge clk);

      // Reset state and first two allocations.
      do_reset();
      fire2();
      chk("lit_rst_rdy", last_rdy, 1);
      chk("lit_rst_s0", last_s0, 1);
      chk("lit_rst_s1", last_s1, 2);
      chk("lit_count61", int'(m_tail - m_head), 61);
      fire2();
      chk("lit_second_s0", last_s0, 3);
      chk("lit_second_s1", last_s1, 4);

      // Single request in slot 1, then empty request group.
      do_reset();
      step(2'b10, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_req10_s1", last_s1, 1);
      step(2'b00, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_req00_s0", last_s0, 2);
      step(2'b00, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_req00_hold", last_s0, 2);

      // Drain until not ready; firing then must not move head.
      do_reset();
      repeat (31) fire2();
      fire2();
      chk("lit_empty_rdy", last_rdy, 0);
      step(2'b10, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      step(2'b00, 1'b0, 2'b01, 9, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      step(2'b11, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_refill_rdy", last_rdy, 1);
      chk("lit_refill_s0", last_s0, 63);
      chk("lit_refill_s1", last_s1, 9);

      // Checkpoint save at head=4, allocate 6 more, recover.
      do_reset();
      fire2();
      fire2();
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b1, 2, 1'b0, 0, 1'b0);
      fire2();
      fire2();
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b1, 2, 1'b0);
      step(2'b11, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_ckpt_s0", last_s0, 5);
      chk("lit_ckpt_s1", last_s1, 6);

      // Retire 4, allocate to head 10, flush with one retire -> head 5.
      do_reset();
      fire2();
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b11, 1'b0, 0, 1'b0, 0, 1'b0);
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b11, 1'b0, 0, 1'b0, 0, 1'b0);
      fire2();
      fire2();
      step(2'b11, 1'b1, 2'b00, 0, 0, 2'b01, 1'b0, 0, 1'b0, 0, 1'b1);
      chk("lit_arat_head", int'(m_head), 5);
      step(2'b11, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_arat_s0", last_s0, 6);
      chk("lit_arat_s1", last_s1, 7);

      // Release {0,7}: only 7 lands at the tail.
      do_reset();
      step(2'b00, 1'b0, 2'b11, 0, 7, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_rel_tail", int'(m_tail), 64);
      repeat (31) fire2();
      step(2'b11, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("lit_rel_s0", last_s0, 63);
      chk("lit_rel_s1", last_s1, 7);

      // Randomized legal traffic.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         req  = 2'($urandom);
         fire = ($urandom_range(0, 3) != 0);
         ren  = 2'($urandom);
         r0   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
         r1   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
         nrel = ((ren[0] && r0 != 0) ? 1 : 0) + ((ren[1] && r1 != 0) ? 1 : 0);
         if (longint'(nrel) > 63 - (m_tail - m_rhead)) ren = 2'b00;
         ret  = 2'($urandom);
         nret = int'(ret[0]) + int'(ret[1]);
         if (longint'(nret) > m_head - m_rhead) begin
            ret  = 2'b00;
            nret = 0;
         end
         sv   = ($urandom_range(0, 3) == 0);
         svi  = int'($urandom_range(0, 3));
         rc   = ($urandom_range(0, 15) == 0);
         rci  = int'($urandom_range(0, 3));
         if (m_ckpt[rci] < m_rhead + nret || m_ckpt[rci] > m_head) rc = 1'b0;
         ar   = ($urandom_range(0, 31) == 0);
         step(req, fire, ren, r0, r1, ret, sv, svi, rc, rci, ar);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hpu_ren_freelist.md
Name: hpu_ren_freelist

Overview:
- Physical-register free list that sits directly upstream of the rename RAT in id0.
- Supplies up to DEC_PARAL new physical destination indices per cycle; these drive the RAT's phy_rdst_index_id0_i.
- Reclaims old destinations released at commit.
- Supports branch-checkpoint recovery and full architectural flush in lockstep with the RAT.
- Implemented as a circular buffer of physical indices with speculative head, committed head and tail pointers.

Parameters:
DEC_PARAL, 2, decode/rename width (slots per cycle)
COMMIT_PARAL, 2, commit width
PHY_SR_LEN, 64, physical registers (power of 2); index 0 is permanently reserved for x0
CKPT_LEN, 4, number of branch checkpoints

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
alloc_req_id0_i  in  DEC_PARAL  per-slot destination request (rdst_act && arc rd != 0)
alloc_fire_id0_i  in  1  id0 group advances this cycle
alloc_rdy_id0_o  out  1  free count >= DEC_PARAL
phy_rdst_index_id0_o  out  DEC_PARAL x log2(PHY_SR_LEN)  allocated index per slot
release_en_i  in  COMMIT_PARAL  commit returns old rdst
release_index_i  in  COMMIT_PARAL x log2(PHY_SR_LEN)  index returned
retire_alloc_en_i  in  COMMIT_PARAL  committed instruction had allocated a destination
ckpt_save_en_id1_i  in  1  save speculative head
ckpt_save_index_id1_i  in  log2(CKPT_LEN)  checkpoint slot
ckpt_rcov_en_i  in  1  restore head from checkpoint
ckpt_rcov_index_i  in  log2(CKPT_LEN)  checkpoint slot
arat_rcov_en_i  in  1  full flush to committed state

Behaviour:
- Storage and pointers:
  - FL_DEPTH = PHY_SR_LEN entries; pointers are log2(FL_DEPTH)+1 bits wide (wrap bit).
  - free count = tail - head, computed modulo 2^(ptr width).
- Reset (synchronous):
  - entry[k] = k+1 for k < PHY_SR_LEN-1.
  - head = 0, rhead = 0, tail = PHY_SR_LEN-1.
  - All checkpoint heads = 0.
  - After reset: alloc_rdy_id0_o = 1; with all requests high, phy_rdst_index_id0_o = {2,1} (slot1, slot0).
  - Reset mid-operation discards all pointer and checkpoint state.
- Allocation (combinational read, zero latency):
  - slot i output = entry[head + popcount(alloc_req_id0_i[i-1:0])].
  - Slots with req=0 output the same candidate as the next requesting slot; this value is don't-care to the consumer.
- Allocation commit:
  - When alloc_fire_id0_i && alloc_rdy_id0_o, head advances by popcount(alloc_req_id0_i).
  - Firing while not ready is a protocol error: no head update (flagged under the optional feature).
  - alloc_rdy_id0_o depends only on registered count, never on the request inputs, so there is no combinational loop.
- Release:
  - Each release_en_i[j] with release_index_i[j] != 0 writes entry[tail + popcount of prior valid releases].
  - tail advances by the valid-release count. Releases of index 0 are ignored.
  - Releases are applied every cycle regardless of recovery.
- Retire: rhead advances by popcount(retire_alloc_en_i) every cycle, including recovery cycles.
- Head update priority (the chosen value is registered, so it appears the next cycle):
  1. arat_rcov_en_i: head <= rhead + this cycle's retire advance.
  2. ckpt_rcov_en_i: head <= ckpt_head[ckpt_rcov_index_i].
  3. Otherwise: the allocation advance.
  - Allocation in a recovery cycle is dropped.
- Checkpoint save:
  - ckpt_head[idx] <= current registered head, i.e. the value before any same-cycle id0 allocation.
  - This matches the RAT snapshot taken in id1.
  - A save and a recovery of the same index in one cycle: recovery reads the old value.
- Boundaries:
  - Count reaching 0 holds rdy low; the block never underflows.
  - Count never exceeds PHY_SR_LEN-1 by construction.
  - Pointer wrap uses modulo arithmetic, so wrap-around is seamless.

Optional Feature:
- Macro HPU_FREELIST_CHK_EN.
- Defined: simulation assertions check
  - fire while not ready;
  - free count > PHY_SR_LEN-1;
  - release of an index already present between head and tail;
  - head passing tail;
  - rhead passing head outside an arat recovery cycle.
  - Also adds a registered shadow occupancy bitmap used for the duplicate check.
- Undefined: no checking logic and no bitmap; functional behaviour is identical.

Decomposition:
- hpu_pkg holds phy_sr_index_t, ckpt_index_t, new fl_ptr_t (log2(PHY_SR_LEN)+1 bits), and constant FL_DEPTH.
- One sub-module, hpu_ren_fl_ckpt: CKPT_LEN x fl_ptr_t register file with one write port (save) and one read port (recover).

Test Plan:
- Reset, both slots request, fire -> outputs {2,1}; next cycle outputs {4,3}, count 61.
- req=2'b10, fire -> slot1 gets the head entry (1), head+1; req=2'b00 fire -> no head change.
- Allocate 63 with no releases -> rdy drops once count <2; a fire while rdy=0 leaves head unchanged (assertion fires with HPU_FREELIST_CHK_EN).
- Save ckpt 2 at head=4, allocate 6 more, ckpt_rcov idx 2 -> next cycle outputs {6,5} again.
- Retire 4 allocations (rhead=4), allocate to head=10, arat_rcov with 1 simultaneous retire -> head=5.
- Release indices {0,7} in one cycle -> only 7 is written at tail; tail+1.
